// File: rtl/alu_hakem.sv
// Round-robin sequencer sharing one combinational 32-bit ALU between the execute
// stage (requester 0) and the branch/address unit (requester 1).
module alu_hakem #(
   parameter int SAYAC_GENISLIK    = 16,
   parameter bit BASLANGIC_ONCELIK = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                istek_gecerli,
   output logic [1:0]                istek_hazir,
   input  logic [31:0]               istek_a0,
   input  logic [31:0]               istek_b0,
   input  logic [3:0]                istek_dnt0,
   input  logic [31:0]               istek_a1,
   input  logic [31:0]               istek_b1,
   input  logic [3:0]                istek_dnt1,
   output logic [31:0]               alu_a,
   output logic [31:0]               alu_b,
   output logic [3:0]                alu_dnt,
   input  logic [31:0]               alu_sonuc,
   input  logic [1:0]                alu_esit_mi,
   output logic [1:0]                yanit_gecerli,
   input  logic [1:0]                yanit_hazir,
   output logic [31:0]               yanit_sonuc,
   output logic [1:0]                yanit_esit_mi,
   output logic                      mesgul,
   output logic [SAYAC_GENISLIK-1:0] sayac0,
   output logic [SAYAC_GENISLIK-1:0] sayac1,
   output logic [1:0]                durum
);

   // Handshake: a request transfers on a rising edge where istek_gecerli[i] and
   // istek_hazir[i] are both high; a response transfers where yanit_gecerli[i]
   // and yanit_hazir[i] are both high. Requesters hold valid/operands until accepted.

   typedef enum logic [1:0] {
      BOS   = 2'd0,
      HESAP = 2'd1,
      YANIT = 2'd2
   } durum_t;

   localparam logic [SAYAC_GENISLIK-1:0] BIR = {{(SAYAC_GENISLIK-1){1'b0}}, 1'b1};

   durum_t st;
   logic   sahip;
   logic   son_kazanan;
   logic   kazanan;

   assign mesgul = (st != BOS);
   assign durum  = st;

   always_comb begin
      kazanan     = 1'b0;
      istek_hazir = 2'b00;
      if (st == BOS) begin
         case (istek_gecerli)
            2'b01:   kazanan = 1'b0;
            2'b10:   kazanan = 1'b1;
            2'b11:   kazanan = ~son_kazanan;
            default: kazanan = 1'b0;
         endcase
         if (istek_gecerli != 2'b00)
            istek_hazir = kazanan ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= BOS;
         sahip         <= 1'b0;
         son_kazanan   <= ~BASLANGIC_ONCELIK;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_dnt       <= '0;
         yanit_gecerli <= 2'b00;
         yanit_sonuc   <= '0;
         yanit_esit_mi <= 2'b00;
         sayac0        <= '0;
         sayac1        <= '0;
      end else begin
         case (st)
            BOS: begin
               if (istek_hazir != 2'b00) begin
                  alu_a       <= kazanan ? istek_a1   : istek_a0;
                  alu_b       <= kazanan ? istek_b1   : istek_b0;
                  alu_dnt     <= kazanan ? istek_dnt1 : istek_dnt0;
                  sahip       <= kazanan;
                  son_kazanan <= kazanan;
                  st          <= HESAP;
               end
            end
            HESAP: begin
               yanit_sonuc   <= alu_sonuc;
               yanit_esit_mi <= alu_esit_mi;
               yanit_gecerli <= sahip ? 2'b10 : 2'b01;
               st            <= YANIT;
            end
            YANIT: begin
               // Only the owner's ready bit can retire the held result.
               if (yanit_hazir[sahip]) begin
                  yanit_gecerli <= 2'b00;
                  if (sahip) sayac1 <= sayac1 + BIR;
                  else       sayac0 <= sayac0 + BIR;
                  st <= BOS;
               end
            end
            default: st <= BOS;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_hakem.sv
// Bench for alu_hakem: directed scenarios plus randomized traffic checked
// against a transaction-level model with an expected queue.
module tb_alu_hakem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  istek_gecerli = 2'b00;
   logic [31:0] istek_a0 = '0, istek_b0 = '0, istek_a1 = '0, istek_b1 = '0;
   logic [3:0]  istek_dnt0 = '0, istek_dnt1 = '0;
   logic [1:0]  yanit_hazir = 2'b11;

   logic [1:0]  istek_hazir, yanit_gecerli, yanit_esit_mi, alu_esit_mi, durum;
   logic [31:0] alu_a, alu_b, alu_sonuc, yanit_sonuc;
   logic [3:0]  alu_dnt;
   logic        mesgul;
   logic [15:0] sayac0, sayac1;

   logic [1:0]  d_istek_hazir, d_yanit_gecerli, d_yanit_esit_mi, d_alu_esit_mi, d_durum;
   logic [31:0] d_alu_a, d_alu_b, d_alu_sonuc, d_yanit_sonuc;
   logic [3:0]  d_alu_dnt;
   logic        d_mesgul;
   logic [1:0]  d_sayac0, d_sayac1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] d);
      case (d)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd13:   return $signed(a) >>> b[4:0];
         default: return a + b;
      endcase
   endfunction

   assign alu_sonuc     = alu_ref(alu_a, alu_b, alu_dnt);
   assign alu_esit_mi   = (alu_sonuc == 32'd0) ? 2'b00 : 2'b01;
   assign d_alu_sonuc   = alu_ref(d_alu_a, d_alu_b, d_alu_dnt);
   assign d_alu_esit_mi = (d_alu_sonuc == 32'd0) ? 2'b00 : 2'b01;

   alu_hakem #(.SAYAC_GENISLIK(16), .BASLANGIC_ONCELIK(1'b0)) dut (
      .clk(clk), .rst(rst), .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
      .istek_a0(istek_a0), .istek_b0(istek_b0), .istek_dnt0(istek_dnt0),
      .istek_a1(istek_a1), .istek_b1(istek_b1), .istek_dnt1(istek_dnt1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_dnt(alu_dnt),
      .alu_sonuc(alu_sonuc), .alu_esit_mi(alu_esit_mi),
      .yanit_gecerli(yanit_gecerli), .yanit_hazir(yanit_hazir),
      .yanit_sonuc(yanit_sonuc), .yanit_esit_mi(yanit_esit_mi),
      .mesgul(mesgul), .sayac0(sayac0), .sayac1(sayac1), .durum(durum)
   );

   alu_hakem #(.SAYAC_GENISLIK(2), .BASLANGIC_ONCELIK(1'b0)) dar (
      .clk(clk), .rst(rst), .istek_gecerli(istek_gecerli), .istek_hazir(d_istek_hazir),
      .istek_a0(istek_a0), .istek_b0(istek_b0), .istek_dnt0(istek_dnt0),
      .istek_a1(istek_a1), .istek_b1(istek_b1), .istek_dnt1(istek_dnt1),
      .alu_a(d_alu_a), .alu_b(d_alu_b), .alu_dnt(d_alu_dnt),
      .alu_sonuc(d_alu_sonuc), .alu_esit_mi(d_alu_esit_mi),
      .yanit_gecerli(d_yanit_gecerli), .yanit_hazir(yanit_hazir),
      .yanit_sonuc(d_yanit_sonuc), .yanit_esit_mi(d_yanit_esit_mi),
      .mesgul(d_mesgul), .sayac0(d_sayac0), .sayac1(d_sayac1), .durum(d_durum)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one operation in flight, {owner, dnt, a, b} per entry.
   logic [68:0] exp_q[$];
   int          gcyc_q[$];
   logic        mbusy = 1'b0;
   logic        lw = 1'b1;
   int          due = 0;
   int          cyc = 0;
   int          cnt0 = 0, cnt1 = 0;
   logic [1:0]  hz_last = 2'b00;
   logic [1:0]  exp_hz;
   logic        w, own;
   logic [68:0] item;
   logic [31:0] e_res;

   always @(negedge clk) begin
      cyc++;
      hz_last = istek_hazir;
      if (rst) begin
         exp_q.delete();
         gcyc_q.delete();
         mbusy = 1'b0;
         lw    = 1'b1;
         cnt0  = 0;
         cnt1  = 0;
      end else begin
         exp_hz = 2'b00;
         w      = 1'b0;
         if (!mbusy && istek_gecerli != 2'b00) begin
            w      = (istek_gecerli == 2'b11) ? ~lw : istek_gecerli[1];
            exp_hz = w ? 2'b10 : 2'b01;
         end
         chk("istek_hazir", istek_hazir, exp_hz);
         chk("mesgul", mesgul, mbusy);
         chk("sayac0", sayac0, cnt0[15:0]);
         chk("sayac1", sayac1, cnt1[15:0]);
         chk("dar_sayac1", d_sayac1, cnt1 % 4);
         if (mbusy) begin
            item  = exp_q[0];
            own   = item[68];
            e_res = alu_ref(item[63:32], item[31:0], item[67:64]);
            if (cyc == due - 1) begin
               chk("alu_a", alu_a, item[63:32]);
               chk("alu_b", alu_b, item[31:0]);
               chk("alu_dnt", alu_dnt, item[67:64]);
            end
            if (cyc >= due) begin
               chk("yanit_gecerli", yanit_gecerli, own ? 2'b10 : 2'b01);
               chk("yanit_sonuc", yanit_sonuc, e_res);
               chk("yanit_esit_mi", yanit_esit_mi, (e_res == 0) ? 2'b00 : 2'b01);
               if (yanit_hazir[own]) begin
                  void'(exp_q.pop_front());
                  if (own) cnt1++; else cnt0++;
                  mbusy = 1'b0;
               end
            end else begin
               chk("yanit_gecerli_idle", yanit_gecerli, 2'b00);
            end
         end else begin
            chk("yanit_gecerli_idle", yanit_gecerli, 2'b00);
         end
         if (exp_hz != 2'b00) begin
            exp_q.push_back(w ? {1'b1, istek_dnt1, istek_a1, istek_b1}
                              : {1'b0, istek_dnt0, istek_a0, istek_b0});
            lw    = w;
            mbusy = 1'b1;
            due   = cyc + 2;
            gcyc_q.push_back(cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      istek_gecerli = 2'b00;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic rand_ops(int r);
      if (r == 0) begin
         istek_a0 = $urandom; istek_b0 = $urandom; istek_dnt0 = 4'($urandom_range(0, 15));
      end else begin
         istek_a1 = $urandom; istek_b1 = $urandom; istek_dnt1 = 4'($urandom_range(0, 15));
      end
   endtask

   // Present one request and return right after the edge that accepted it.
   task automatic tek_islem(int r, logic [31:0] a, logic [31:0] b, logic [3:0] d);
      int k;
      if (r == 0) begin istek_a0 = a; istek_b0 = b; istek_dnt0 = d; end
      else        begin istek_a1 = a; istek_b1 = b; istek_dnt1 = d; end
      istek_gecerli[r] = 1'b1;
      k = 0;
      do begin
         step();
         k++;
      end while (!hz_last[r] && k < 40);
      if (!hz_last[r]) chk("grant_timeout", hz_last[r], 1);
      istek_gecerli[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (mbusy && k < 60) begin
         step();
         k++;
      end
      if (mbusy) chk("idle_timeout", mbusy, 1'b0);
   endtask

   int g_ord[$];

   initial begin
      // Reset values
      step(); step();
      chk("rst_istek_hazir", istek_hazir, 2'b00);
      chk("rst_yanit_gecerli", yanit_gecerli, 2'b00);
      chk("rst_mesgul", mesgul, 1'b0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_dnt", alu_dnt, 4'd0);
      chk("rst_yanit_sonuc", yanit_sonuc, 32'd0);
      chk("rst_yanit_esit_mi", yanit_esit_mi, 2'b00);
      chk("rst_sayac0", sayac0, 16'd0);
      chk("rst_sayac1", sayac1, 16'd0);
      rst = 1'b0;

      // Requester 0: 5 + 7
      tek_islem(0, 32'd5, 32'd7, 4'b0000);
      step();
      chk("r0_add_gecerli", yanit_gecerli, 2'b01);
      chk("r0_add_sonuc", yanit_sonuc, 32'd12);
      chk("r0_add_esit", yanit_esit_mi, 2'b01);
      wait_idle();
      chk("r0_add_sayac0", sayac0, 16'd1);

      // Requester 1: 9 - 9
      tek_islem(1, 32'd9, 32'd9, 4'b0001);
      step();
      chk("r1_sub_gecerli", yanit_gecerli, 2'b10);
      chk("r1_sub_sonuc", yanit_sonuc, 32'd0);
      chk("r1_sub_esit", yanit_esit_mi, 2'b00);
      wait_idle();

      // Fairness: both continuously valid
      do_reset();
      yanit_hazir = 2'b11;
      rand_ops(0); rand_ops(1);
      istek_gecerli = 2'b11;
      for (int k = 0; k < 60 && g_ord.size() < 4; k++) begin
         step();
         if (hz_last != 2'b00) begin
            g_ord.push_back(int'(hz_last[1]));
            if (g_ord.size() == 4) istek_gecerli = 2'b00;
            else rand_ops(int'(hz_last[1]));
         end
      end
      chk("fair_grant_count", g_ord.size(), 4);
      for (int i = 0; i < g_ord.size(); i++) chk("fair_order", g_ord[i], i % 2);
      wait_idle();
      chk("fair_sayac0", sayac0, 16'd2);
      chk("fair_sayac1", sayac1, 16'd2);
      for (int i = 0; i + 1 < gcyc_q.size(); i++)
         chk("fair_period", gcyc_q[i+1] - gcyc_q[i], 3);

      // Held response while requester 1 waits; non-owner ready is ignored
      yanit_hazir = 2'b10;
      tek_islem(0, 32'hFFFF_FFF8, 32'd1, 4'b1101);
      rand_ops(1);
      istek_gecerli[1] = 1'b1;
      step();
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_sonuc", yanit_sonuc, 32'hFFFF_FFFC);
         chk("hold_istek_hazir", istek_hazir, 2'b00);
         chk("hold_mesgul", mesgul, 1'b1);
      end
      yanit_hazir = 2'b11;
      step();
      step();
      chk("hold_r1_next", hz_last, 2'b10);
      istek_gecerli = 2'b00;
      wait_idle();

      // Reset while the ALU result is being captured
      tek_islem(0, 32'd3, 32'd4, 4'b0000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_gecerli", yanit_gecerli, 2'b00);
      chk("rst_mid_mesgul", mesgul, 1'b0);
      chk("rst_mid_sayac0", sayac0, 16'd0);
      chk("rst_mid_sayac1", sayac1, 16'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rst_mid_no_resp", yanit_gecerli, 2'b00);
      end

      // Counter wrap on the 2-bit instance
      for (int k = 0; k < 5; k++) begin
         tek_islem(1, $urandom, $urandom, 4'($urandom_range(0, 15)));
         wait_idle();
      end
      chk("wrap_sayac1", sayac1, 16'd5);
      chk("wrap_dar_sayac1", d_sayac1, 2'd1);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (hz_last[r] || !istek_gecerli[r]) begin
               istek_gecerli[r] = 1'($urandom_range(0, 1));
               rand_ops(r);
            end else if ($urandom_range(0, 7) == 0) begin
               istek_gecerli[r] = 1'b0;
            end
         end
         yanit_hazir = 2'($urandom_range(0, 3));
         step();
      end
      istek_gecerli = 2'b00;
      yanit_hazir   = 2'b11;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_hakem.md
Name: alu_hakem

Overview:
- Round-robin arbiter/sequencer that shares the single 32-bit ALU instance between two requesters: requester 0 is the execute stage and requester 1 is the branch/address unit.
- Each accepted request is latched, presented to the ALU for one cycle, and the ALU result and esit_mi flag are registered.
- The registered result is held until the owning requester accepts it.
- Sits between the requesters and the ALU; the ALU itself stays purely combinational.

Parameters:
- SAYAC_GENISLIK, 16, width of per-requester completed-operation counters.
- BASLANGIC_ONCELIK, 0, requester that wins the first simultaneous request after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- istek_gecerli  input  2  per-requester request valid; bit i belongs to requester i.
- istek_hazir  output  2  per-requester request accepted this cycle.
- istek_a0, istek_b0  input  32 each  requester 0 operands (signed).
- istek_dnt0  input  4  requester 0 ALU function select.
- istek_a1, istek_b1  input  32 each  requester 1 operands (signed).
- istek_dnt1  input  4  requester 1 ALU function select.
- alu_a, alu_b  output  32 each  operands driven to ALU; registered.
- alu_dnt  output  4  function select to ALU; registered.
- alu_sonuc  input  32  ALU result.
- alu_esit_mi  input  2  ALU zero flag (00 = zero, 01 = nonzero).
- yanit_gecerli  output  2  per-requester response valid.
- yanit_hazir  input  2  per-requester response accepted by consumer.
- yanit_sonuc  output  32  registered result; meaningful only while a yanit_gecerli bit is high.
- yanit_esit_mi  output  2  registered esit_mi.
- mesgul  output  1  high whenever the state is not BOS.
- sayac0, sayac1  output  SAYAC_GENISLIK each  completed-operation counts.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state goes to BOS; istek_hazir, yanit_gecerli and mesgul are 0.
  - alu_a, alu_b, alu_dnt, yanit_sonuc, yanit_esit_mi, sayac0 and sayac1 are 0.
  - son_kazanan is set to the complement of BASLANGIC_ONCELIK.
  - Reset mid-operation drops any latched request or pending result; no counter increments.
- States: BOS (idle), HESAP (ALU evaluating), YANIT (holding result).
- BOS:
  - istek_hazir is combinational from istek_gecerli and son_kazanan. Only one bit may be high.
  - Single requester valid: that requester wins.
  - Both valid: the requester != son_kazanan wins.
  - On a grant at edge N, latch the winner's a, b, dnt into alu_a, alu_b, alu_dnt. Record the owner and update son_kazanan to the owner. Move to HESAP.
  - No valid request: stay in BOS; alu_* hold their previous values.
- HESAP (cycle N+1):
  - Register alu_sonuc and alu_esit_mi into yanit_sonuc and yanit_esit_mi.
  - Set yanit_gecerli[owner]=1 and move to YANIT.
  - istek_hazir=0.
- YANIT:
  - yanit_gecerli[owner] stays high; yanit_sonuc and yanit_esit_mi stay stable.
  - When yanit_hazir[owner]=1: clear yanit_gecerli, increment the owner's counter (wraps modulo 2^SAYAC_GENISLIK), move to BOS.
  - yanit_hazir on the non-owner bit is ignored.
  - istek_hazir=0; new requests wait.
- Latency and throughput:
  - Response is valid 2 cycles after the accept edge.
  - Minimum period is 3 cycles per operation.
  - No overlap between operations.
- Requester rules:
  - A requester must hold its valid and operands stable until its istek_hazir is seen high.
  - Dropping valid before the grant is allowed; no grant results.
- Function codes:
  - dnt codes 1110 and 1111 are passed through unchanged; the ALU treats them as add.
  - The arbiter never alters operands or the code.
- Fairness: with both requesters continuously valid, grants strictly alternate.

Test Plan:
- After reset, requester 0 sends a=5, b=7, dnt=0000 → istek_hazir=01 in the accept cycle. yanit_gecerli=01 two cycles later with yanit_sonuc=12, yanit_esit_mi=01, then sayac0=1.
- Requester 1 sends a=9, b=9, dnt=0001 → yanit_gecerli=10, yanit_sonuc=0, yanit_esit_mi=00.
- Both requesters valid every cycle with BASLANGIC_ONCELIK=0 and yanit_hazir=11 → grant order 0,1,0,1. After 4 responses sayac0=2, sayac1=2, one operation every 3 cycles.
- Requester 0 sends a=-8, b=1, dnt=1101 and holds yanit_hazir[0]=0 for 5 cycles while requester 1 stays valid → yanit_sonuc stays 0xFFFFFFFC. istek_hazir stays 00 and mesgul stays 1 until acceptance; requester 1 is granted on the cycle after.
- Assert rst during HESAP → next cycle state is BOS, yanit_gecerli=00, counters 0, and no response is ever delivered for that request.
- With SAYAC_GENISLIK=2, requester 1 completes 5 operations → sayac1 reads 1 (wraps).
